// File: rtl/rgb_to_hsi_win_paint_pkg.sv
// Shared constants and pipeline stage types for the RGB to HSI converter.
// The output scale follows the Windows Paint convention, where hue, saturation
// and lightness all run over 0..240 and hue 240 is the same as hue 0.
package rgb_to_hsi_win_paint_pkg;

  // Full scale of hue, saturation and lightness.
  localparam int HSL_MAX    = 240;
  // Hue width of one colour sector (six sectors make a full turn).
  localparam int HUE_SECTOR = 40;
  // Hue reported for greys, where hue is otherwise undefined.
  localparam int GREY_HUE   = 160;
  // Cycles from input launch to output, and the depth of the valid pipe.
  localparam int PIPE_LAT   = 4;

  // Half of the largest possible max+min sum. It splits the saturation
  // formula into its dark and light halves.
  localparam int HALF_SUM   = 255;
  localparam int FULL_SUM   = 510;

  // Lightness is sum*240/510. It is evaluated as sum*120/255 so that the
  // numerator stays within 16 bits. Rounding is unchanged because the
  // half-up rounding scales with the ratio.
  localparam int I_SCALE    = HSL_MAX / 2;

  // Hue offsets of the green- and blue-dominant sectors.
  localparam int HUE_BASE_G = 2 * HUE_SECTOR;
  localparam int HUE_BASE_B = 4 * HUE_SECTOR;

  // Which channel holds the maximum. Ties resolve to R, then G, then B.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  // Stage 2 register contents: extremes reduced to delta/sum plus the
  // signed hue difference for the dominant channel.
  typedef struct packed {
    logic [7:0]        delta;
    logic [8:0]        sum;
    logic signed [8:0] diff;
    chan_e             chan;
  } stage2_t;

  // Stage 3 register contents: the numerator and denominator for each of
  // the three dividers, plus what the hue wrap needs.
  typedef struct packed {
    logic [15:0] h_num;
    logic [8:0]  h_den;
    logic        h_neg;
    logic [7:0]  base;
    logic        grey;
    logic [15:0] s_num;
    logic [8:0]  s_den;
    logic [15:0] i_num;
  } stage3_t;

endpackage

// File: rtl/rgb_to_hsi_win_paint_div.sv
// hsi_div_round: combinational unsigned divider that rounds half-up.
//   num : 16-bit numerator
//   den : 9-bit denominator
//   quo : 8-bit quotient, round(num/den) = (2*num + den) / (2*den)
// A zero denominator yields 0. The pipeline never presents one, but the
// guard keeps the hardware well defined. Quotients above 255 saturate.
module hsi_div_round (
  input  logic [15:0] num,
  input  logic [8:0]  den,
  output logic [7:0]  quo
);

  logic [17:0] num_x2;
  logic [9:0]  den_x2;
  logic [17:0] q_full;

  // Adding the denominator before halving turns truncation into
  // round-half-up.
  always_comb begin
    num_x2 = {1'b0, num, 1'b0} + 18'(den);
    den_x2 = {den, 1'b0};
    q_full = '0;
    if (den != 9'd0) begin
      q_full = num_x2 / 18'(den_x2);
    end
    quo = (q_full > 18'd255) ? 8'hFF : q_full[7:0];
  end

endmodule

// File: rtl/rgb_to_hsi_win_paint.sv
// rgb_to_hsi_win_paint: pipelined RGB888 to HSI converter on the Paint
// 0..240 scale. It accepts one pixel per clock, has a fixed 4-cycle latency
// and no back-pressure.
//   clk, rst      : clock; asynchronous active-high reset
//   Rin/Gin/Bin   : 8-bit colour channels
//   RGBinEn       : input valid
//   H, S, I       : hue 0..239, saturation 0..240, lightness 0..240
//   HSIoutEn      : output valid (RGBinEn delayed 4 cycles)
// Stages: 1 registers the inputs, 2 finds the extremes and the dominant
// channel, 3 builds the divider operands, 4 divides, wraps the hue and
// registers the outputs.
module rgb_to_hsi_win_paint
  import rgb_to_hsi_win_paint_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Rin,
  input  logic [7:0] Gin,
  input  logic [7:0] Bin,
  input  logic       RGBinEn,
  output logic [7:0] H,
  output logic [7:0] S,
  output logic [7:0] I,
  output logic       HSIoutEn
);

  localparam logic signed [9:0] HUE_WRAP = 10'(HSL_MAX);

  // Stage 1 registers
  logic [7:0] r1, g1, b1;

  // Stage 2 combinational results and registers
  logic [7:0] mx, mn;
  chan_e      chan_sel;
  stage2_t    st2_next, st2;

  // Stage 3 combinational results and registers
  logic [7:0] abs_diff;
  stage3_t    st3_next, st3;

  // Stage 4 divider outputs and hue wrap
  logic [7:0]        h_q, s_q, i_q;
  logic signed [9:0] hue_raw;
  logic [7:0]        hue_next;

  // Valid flag travelling alongside the data. Its last bit is the output
  // valid, so reset clears HSIoutEn immediately.
  logic [PIPE_LAT-1:0] valid_pipe;

  // Stage 2: find max/min with R > G > B tie priority. The signed
  // difference of the two non-dominant channels sets the direction within
  // the sector.
  always_comb begin
    chan_sel = CH_R;
    mx       = r1;
    if (r1 >= g1 && r1 >= b1) begin
      chan_sel = CH_R;
      mx       = r1;
    end else if (g1 >= b1) begin
      chan_sel = CH_G;
      mx       = g1;
    end else begin
      chan_sel = CH_B;
      mx       = b1;
    end

    mn = r1;
    if (g1 < mn) mn = g1;
    if (b1 < mn) mn = b1;

    st2_next       = '0;
    st2_next.delta = mx - mn;
    st2_next.sum   = {1'b0, mx} + {1'b0, mn};
    st2_next.chan  = chan_sel;
    case (chan_sel)
      CH_G:    st2_next.diff = $signed({1'b0, b1}) - $signed({1'b0, r1});
      CH_B:    st2_next.diff = $signed({1'b0, r1}) - $signed({1'b0, g1});
      default: st2_next.diff = $signed({1'b0, g1}) - $signed({1'b0, b1});
    endcase
  end

  // Stage 3: divider operands. Greys get a unit denominator and a zero
  // numerator so that the dividers stay well defined. Their hue and
  // saturation are overridden later by the grey flag.
  always_comb begin
    abs_diff = st2.diff[8] ? 8'(-st2.diff) : st2.diff[7:0];

    st3_next       = '0;
    st3_next.grey  = (st2.delta == 8'd0);
    st3_next.h_neg = st2.diff[8];
    st3_next.h_num = {8'd0, abs_diff} * 16'(HUE_SECTOR);
    st3_next.s_num = {8'd0, st2.delta} * 16'(HSL_MAX);
    st3_next.i_num = {7'd0, st2.sum} * 16'(I_SCALE);

    case (st2.chan)
      CH_G:    st3_next.base = 8'(HUE_BASE_G);
      CH_B:    st3_next.base = 8'(HUE_BASE_B);
      default: st3_next.base = 8'd0;
    endcase

    if (st2.delta == 8'd0) begin
      st3_next.h_den = 9'd1;
      st3_next.s_den = 9'd1;
    end else begin
      st3_next.h_den = {1'b0, st2.delta};
      // Light colours measure saturation against the distance to white.
      if (st2.sum <= 9'(HALF_SUM)) begin
        st3_next.s_den = st2.sum;
      end else begin
        st3_next.s_den = 9'(FULL_SUM) - st2.sum;
      end
    end
  end

  hsi_div_round u_div_h (
    .num (st3.h_num),
    .den (st3.h_den),
    .quo (h_q)
  );

  hsi_div_round u_div_s (
    .num (st3.s_num),
    .den (st3.s_den),
    .quo (s_q)
  );

  hsi_div_round u_div_i (
    .num (st3.i_num),
    .den (9'(HALF_SUM)),
    .quo (i_q)
  );

  // Stage 4 hue: offset the sector base by the rounded fraction. A
  // negative result wraps into the top of the circle, and a full turn
  // folds back to 0.
  always_comb begin
    if (st3.h_neg) begin
      hue_raw = $signed({2'b00, st3.base}) - $signed({2'b00, h_q});
    end else begin
      hue_raw = $signed({2'b00, st3.base}) + $signed({2'b00, h_q});
    end

    if (hue_raw < 10'sd0) begin
      hue_next = 8'(hue_raw + HUE_WRAP);
    end else if (hue_raw == HUE_WRAP) begin
      hue_next = 8'd0;
    end else begin
      hue_next = 8'(hue_raw);
    end
  end

  // Every pipeline register advances each cycle regardless of valid.
  // Reset clears the whole pipe so that in-flight pixels are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1         <= '0;
      g1         <= '0;
      b1         <= '0;
      st2        <= '0;
      st3        <= '0;
      H          <= '0;
      S          <= '0;
      I          <= '0;
      valid_pipe <= '0;
    end else begin
      r1         <= Rin;
      g1         <= Gin;
      b1         <= Bin;
      st2        <= st2_next;
      st3        <= st3_next;
      H          <= st3.grey ? 8'(GREY_HUE) : hue_next;
      S          <= st3.grey ? 8'd0 : s_q;
      I          <= i_q;
      valid_pipe <= {valid_pipe[PIPE_LAT-2:0], RGBinEn};
    end
  end

  assign HSIoutEn = valid_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_rgb_to_hsi_win_paint.sv
// Self-checking bench for rgb_to_hsi_win_paint. Expected triples are queued
// when a valid pixel is driven and compared when HSIoutEn is seen.
module tb_rgb_to_hsi_win_paint;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] Rin = '0, Gin = '0, Bin = '0;
  logic       RGBinEn = 1'b0;
  logic [7:0] H, S, I;
  logic       HSIoutEn;

  typedef struct {
    int r, g, b;
    int h, s, i;
  } exp_t;

  exp_t sb[$];

  int testsRun      = 0;
  int testsFailed   = 0;
  int cycle         = 0;
  int outCount      = 0;
  int firstOutCycle = -1;
  int startCycle    = 0;

  // Reference pixels with hand-derived results: R, G, B, H, S, I.
  // The pink tint (255,230,231) has diff=-1 and delta=25, so m = 1.6, which
  // rounds to 2. That gives hue -2, which wraps to 238.
  int tbl [16][6] = '{
    '{255, 255,   0,  40, 240, 120},
    '{255,   0,   0,   0, 240, 120},
    '{  0, 255,   0,  80, 240, 120},
    '{  0, 255, 255, 120, 240, 120},
    '{  0,   0, 255, 160, 240, 120},
    '{255,   0, 255, 200, 240, 120},
    '{  0,   0,   0, 160,   0,   0},
    '{119, 119, 119, 160,   0, 112},
    '{255, 255, 255, 160,   0, 240},
    '{192, 108,  63,  14, 121, 120},
    '{ 79,  80,  37,  41,  88,  55},
    '{ 88, 136,  83,  76,  58, 103},
    '{ 90, 173, 194, 128, 110, 134},
    '{252, 182, 243, 205, 221, 204},
    '{255, 230, 231, 238, 240, 228},
    '{111, 222,  77,  71, 165, 141}
  };

  rgb_to_hsi_win_paint dut (
    .clk      (clk),
    .rst      (rst),
    .Rin      (Rin),
    .Gin      (Gin),
    .Bin      (Bin),
    .RGBinEn  (RGBinEn),
    .H        (H),
    .S        (S),
    .I        (I),
    .HSIoutEn (HSIoutEn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model written straight from the colour-space definition,
  // using the unscaled 240/510 lightness ratio.
  function automatic exp_t model(input int r, input int g, input int b);
    exp_t e;
    int mx, mn, delta, sum, den, base, diff, absd, m, h;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    delta = mx - mn;
    sum   = mx + mn;
    e.r = r; e.g = g; e.b = b;
    e.i = (2 * sum * 240 + 510) / 1020;
    if (delta == 0) begin
      e.s = 0;
      e.h = 160;
    end else begin
      den = (sum <= 255) ? sum : 510 - sum;
      e.s = (2 * delta * 240 + den) / (2 * den);
      if (r == mx) begin
        base = 0;   diff = g - b;
      end else if (g == mx) begin
        base = 80;  diff = b - r;
      end else begin
        base = 160; diff = r - g;
      end
      absd = (diff < 0) ? -diff : diff;
      m = (80 * absd + delta) / (2 * delta);
      h = (diff >= 0) ? base + m : base - m;
      if (h < 0) h = h + 240;
      if (h == 240) h = 0;
      e.h = h;
    end
    return e;
  endfunction

  // Drive one cycle of input just after the rising edge and queue the
  // expected result of every valid pixel.
  task automatic applyStimulus(input int r, input int g, input int b, input bit en,
                               input bit useModel, input int h, input int s, input int i);
    exp_t e;
    @(posedge clk);
    #1;
    Rin     = 8'(r);
    Gin     = 8'(g);
    Bin     = 8'(b);
    RGBinEn = en;
    if (en) begin
      if (useModel) begin
        e = model(r, g, b);
      end else begin
        e.r = r; e.g = g; e.b = b; e.h = h; e.s = s; e.i = i;
      end
      sb.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic clearCounters();
    outCount      = 0;
    firstOutCycle = -1;
  endtask

  // Output monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    string px;
    if (!rst && HSIoutEn) begin
      outCount++;
      if (firstOutCycle < 0) firstOutCycle = cycle;
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        e  = sb.pop_front();
        px = $sformatf("(%0d,%0d,%0d)", e.r, e.g, e.b);
        checkOutput({"H", px}, int'(H), e.h);
        checkOutput({"S", px}, int'(S), e.s);
        checkOutput({"I", px}, int'(I), e.i);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, g, b;
    bit en;

    // Outputs while reset is held.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_H", int'(H), 0);
    checkOutput("reset_S", int'(S), 0);
    checkOutput("reset_I", int'(I), 0);
    checkOutput("reset_valid", int'(HSIoutEn), 0);
    @(negedge clk);
    rst = 1'b0;

    idleCycles(3);
    checkOutput("idle_valid", int'(HSIoutEn), 0);

    // Sixteen reference pixels back to back. Check the valid window and
    // the latency.
    $display("[TB] reference pixels, back-to-back");
    clearCounters();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(tbl[k][0], tbl[k][1], tbl[k][2], 1'b1, 1'b0,
                    tbl[k][3], tbl[k][4], tbl[k][5]);
      if (k == 0) startCycle = cycle;
    end
    idleCycles(8);
    checkOutput("burst_out_count", outCount, 16);
    checkOutput("burst_latency", firstOutCycle - startCycle, 4);
    checkOutput("burst_queue_empty", sb.size(), 0);

    // Random pixels with random gaps, checked against the model.
    $display("[TB] random pixels");
    for (int k = 0; k < 60; k++) begin
      r  = $urandom_range(0, 255);
      g  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      if (k % 7 == 3) g = r;
      en = ($urandom_range(0, 3) != 0);
      applyStimulus(r, g, b, en, 1'b1, 0, 0, 0);
    end
    idleCycles(8);
    checkOutput("random_queue_empty", sb.size(), 0);

    // Reset in the middle of a burst drops everything in flight.
    $display("[TB] reset mid-burst");
    for (int k = 0; k < 6; k++) begin
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), 1'b1, 1'b1, 0, 0, 0);
    end
    @(posedge clk);
    #3;
    rst     = 1'b1;
    RGBinEn = 1'b0;
    #1;
    checkOutput("midreset_valid", int'(HSIoutEn), 0);
    checkOutput("midreset_H", int'(H), 0);
    checkOutput("midreset_S", int'(S), 0);
    checkOutput("midreset_I", int'(I), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    clearCounters();
    applyStimulus(192, 108, 63, 1'b1, 1'b0, 14, 121, 120);
    startCycle = cycle;
    idleCycles(8);
    checkOutput("post_reset_out_count", outCount, 1);
    checkOutput("post_reset_latency", firstOutCycle - startCycle, 4);
    checkOutput("post_reset_queue_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
